// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

    localparam int          WORD_W      = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'hE1A0_0000;

    // One fetched instruction as it travels from the ROM response to decode.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } fetch_pkt_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~WORD_W'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small circular skid buffer holding fetched packets between the ROM response and decode.
// Flush empties the buffer in one cycle; a push in the flush cycle is discarded.
module fetch_skid_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_pkt_t       push_pkt,
    input  logic             pop,
    input  logic             flush,
    output fetch_pkt_t       head_pkt,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    fetch_pkt_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Packet storage: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_pkt;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_pkt = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side master of the instruction ROM: owns the PC, tracks the one-cycle ROM
// response, substitutes NOP on off-end fetches and hands words to decode via a skid FIFO.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 4,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              br_valid,
    input  logic [WORD_W-1:0] br_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_inst,
    output logic [WORD_W-1:0] out_pc,
    output logic              out_fault
);

    localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * INSTR_BYTES);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] rsp_pc_q;
    logic              rsp_vld_q;
    logic              deq;
    logic              issue;
    logic              push;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  count;
    logic              empty;
    fetch_pkt_t        push_pkt;
    fetch_pkt_t        head_pkt;

    assign deq = out_valid && out_ready;

    // Slots already committed (buffered plus in-flight, minus the one leaving now)
    // decide whether another ROM read may be started without overflowing.
    always_comb begin
        occupancy = (CNT_W + 1)'(count) + (CNT_W + 1)'(rsp_vld_q) - (CNT_W + 1)'(deq);
        issue     = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    end

    // PC and response-valid tracking; a redirect drops the in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            rsp_vld_q <= 1'b0;
        end else if (br_valid) begin
            pc_q      <= align_word(br_target);
            rsp_vld_q <= 1'b0;
        end else if (issue) begin
            pc_q      <= pc_q + WORD_W'(INSTR_BYTES);
            rsp_vld_q <= 1'b1;
        end else begin
            rsp_vld_q <= 1'b0;
        end
    end

    // Remember which address the ROM is answering next cycle.
    always_ff @(posedge clk) begin
        if (issue && !br_valid) begin
            rsp_pc_q <= pc_q;
        end
    end

    // Build the packet for the returning word; off-end addresses become a faulting NOP.
    always_comb begin
        push_pkt.pc    = rsp_pc_q;
        push_pkt.fault = (rsp_pc_q >= IMEM_LIMIT);
        push_pkt.inst  = push_pkt.fault ? NOP_INSTR : imem_data;
    end

    assign push      = rsp_vld_q && !br_valid;
    assign imem_addr = pc_q;

    fetch_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_pkt (push_pkt),
        .pop      (deq),
        .flush    (br_valid),
        .head_pkt (head_pkt),
        .count    (count),
        .empty    (empty)
    );

    // Present the FIFO head; outputs read as zero while nothing is buffered.
    always_comb begin
        out_valid = !empty;
        out_inst  = out_valid ? head_pkt.inst  : '0;
        out_pc    = out_valid ? head_pkt.pc    : '0;
        out_fault = out_valid ? head_pkt.fault : 1'b0;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected packets, a monitor
// pops and compares on every accepted transfer and checks stability under stall.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        br_valid;
    logic [31:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;

    int tests = 0;
    int fails = 0;
    int n_pop = 0;
    int p0;
    fetch_pkt_t exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .br_valid  (br_valid),
        .br_target (br_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_fault (out_fault)
    );

    // Instruction ROM: registered read, garbage beyond the populated words.
    function automatic logic [31:0] rom_read(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hE3A0_2005;
            32'h4:   return 32'hE3A0_3008;
            32'h8:   return 32'hE083_4005;
            32'hC:   return 32'hEA00_002A;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) imem_data <= rom_read(imem_addr);

    // Expected packet for a fetch address, hand-listed.
    function automatic fetch_pkt_t exp_pkt(input logic [31:0] pc);
        fetch_pkt_t e;
        e.pc = pc;
        e.fault = 1'b0;
        case (pc)
            32'h0:   e.inst = 32'hE3A0_2005;
            32'h4:   e.inst = 32'hE3A0_3008;
            32'h8:   e.inst = 32'hE083_4005;
            32'hC:   e.inst = 32'hEA00_002A;
            default: begin e.inst = 32'hE1A0_0000; e.fault = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_pkt(start + 32'(i * 4)));
    endtask

    // Monitor: compare each accepted transfer with the scoreboard; check hold under stall.
    initial begin
        fetch_pkt_t held;
        fetch_pkt_t e;
        logic prev_stall;
        logic prev_flush;
        prev_stall = 1'b0;
        prev_flush = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (out_valid && prev_stall && !prev_flush) begin
                check32("stall_inst", out_inst, held.inst);
                check32("stall_pc", out_pc, held.pc);
                check32("stall_fault", 32'(out_fault), 32'(held.fault));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer: got pc %h, expected no transfer", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("sb_pc", out_pc, e.pc);
                    check32("sb_inst", out_inst, e.inst);
                    check32("sb_fault", 32'(out_fault), 32'(e.fault));
                    n_pop++;
                end
            end
            prev_stall = out_valid && !out_ready && rst_n;
            prev_flush = br_valid || !rst_n;
            held.inst  = out_inst;
            held.pc    = out_pc;
            held.fault = out_fault;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic [31:0] targets [6];
        targets = '{32'h0, 32'h4, 32'hA, 32'hC, 32'h10, 32'hFFFF_FFF8};
        rst_n = 1'b0;
        out_ready = 1'b1;
        br_valid = 1'b0;
        br_target = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_valid", 32'(out_valid), 32'h0);
        check32("rst_inst", out_inst, 32'h0);
        check32("rst_pc", out_pc, 32'h0);
        check32("rst_fault", 32'(out_fault), 32'h0);
        check32("rst_addr", imem_addr, 32'h0);

        // Stream from reset with decode always ready, running past the ROM end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_stream(32'h0, 64);
        p0 = n_pop;
        @(posedge clk);
        @(negedge clk);
        check32("a_lat_valid0", 32'(out_valid), 32'h0);
        @(negedge clk);
        check32("a_first_valid", 32'(out_valid), 32'h1);
        check32("a_first_pc", out_pc, 32'h0);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        check32("a_count", 32'(n_pop - p0), 32'd9);

        // Stall then reset mid-stream
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check32("rst_mid_valid", 32'(out_valid), 32'h0);
        check32("rst_mid_pc", out_pc, 32'h0);
        exp_q.delete();

        // Restart with decode stalled for five cycles after the first valid
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        push_stream(32'h0, 64);
        p0 = n_pop;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("b_first_valid", 32'(out_valid), 32'h1);
        check32("b_first_pc", out_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("b_hold_pc", out_pc, 32'h0);
            check32("b_count_le2", 32'(dut.u_fifo.count <= 2), 32'h1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        check32("b_release_count", 32'(n_pop - p0), 32'd4);

        // Fill the FIFO, then redirect to an unaligned target
        out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check32("c_fifo_full", 32'(dut.u_fifo.count), 32'd2);
        br_valid = 1'b1;
        br_target = 32'h0000_0009;
        @(posedge clk); #1;
        br_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h8, 64);
        p0 = n_pop;
        out_ready = 1'b1;
        @(negedge clk);
        check32("c_flush_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        check32("c_lat_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        check32("c_tgt_valid", 32'(out_valid), 32'h1);
        check32("c_tgt_pc", out_pc, 32'h8);
        check32("c_tgt_inst", out_inst, 32'hE083_4005);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        check32("c_count", 32'(n_pop - p0), 32'd5);

        // Redirect near the top of the address space while a transfer completes
        br_valid = 1'b1;
        br_target = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        br_valid = 1'b0;
        exp_q.delete();
        push_stream(32'hFFFF_FFFC, 512);
        p0 = n_pop;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        check32("d_wrap_count", 32'(n_pop - p0), 32'd4);

        // Random decode back-pressure with occasional redirects
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                br_valid = 1'b1;
                br_target = targets[$urandom_range(0, 5)];
                @(posedge clk); #1;
                br_valid = 1'b0;
                exp_q.delete();
                push_stream(br_target & 32'hFFFF_FFFC, 512);
            end else begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
